// File: rtl/div_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
// Holds the scheduler state encoding, operand widths, the iteration count
// and the quotient returned for a zero divisor.
package div_pkg;

  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned ITER  = 8;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [DVD_W-1:0] DIVZERO_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/div_core.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   start_i       load operands and begin a division
//   dividend_i    8-bit dividend, sampled on start_i
//   divisor_i     4-bit divisor, sampled on start_i
//   done_c        high during the final iteration
//   quotient_c    quotient as it will be after the current iteration
//   remainder_c   remainder as it will be after the current iteration
module div_core
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_c,
  output logic [DVD_W-1:0] quotient_c,
  output logic [DVS_W-1:0] remainder_c
);

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DVS_W:0]   part;
  logic             ge;
  logic [DVS_W-1:0] rem_step;
  logic [DVD_W-1:0] quo_step;

  // One restoring step; a zero divisor always subtracts nothing, so the
  // quotient fills with ones and the remainder collects the low dividend bits.
  always_comb begin
    part     = {rem_q, dvd_q[DVD_W-1]};
    ge       = (part >= {1'b0, dvs_q});
    rem_step = ge ? DVS_W'(part - {1'b0, dvs_q}) : DVS_W'(part);
    quo_step = {quo_q[DVD_W-2:0], ge};
  end

  assign done_c      = run_q && (cnt_q == CNT_W'(ITER - 1));
  assign quotient_c  = quo_step;
  assign remainder_c = rem_step;

  // Next-state for operand, shift and counter registers
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      dvd_d = dividend_i;
      dvs_d = divisor_i;
      rem_d = '0;
      quo_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential divider among NREQ requesters.
// Optional feature macro: DIV_ZERO_CHECK_EN (zero divisor short-cuts to RESP).
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   req_valid        per-requester request pending
//   req_dividend     packed 8-bit dividends, requester i at [8i+7:8i]
//   req_divisor      packed 4-bit divisors, requester i at [4i+3:4i]
//   req_ready        one-hot grant, only in IDLE
//   rsp_valid/ready  response handshake
//   rsp_id           requester that owns the response
//   rsp_quotient     unsigned quotient
//   rsp_remainder    unsigned remainder
//   rsp_divzero      divisor was zero (macro builds only, else 0)
//   busy             scheduler not in IDLE
module div_arbiter
  import div_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [DVD_W*NREQ-1:0] req_dividend,
  input  logic [DVS_W*NREQ-1:0] req_divisor,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DVD_W-1:0]      rsp_quotient,
  output logic [DVS_W-1:0]      rsp_remainder,
  output logic                  rsp_divzero,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [DVD_W-1:0] rsp_quot_q, rsp_quot_d;
  logic [DVS_W-1:0] rsp_rem_q, rsp_rem_d;
  logic             busy_q, busy_d;
`ifdef DIV_ZERO_CHECK_EN
  logic             rsp_dz_q, rsp_dz_d;
`endif

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [NREQ-1:0]  grant_oh;
  int unsigned      idx;
  logic [DVD_W-1:0] sel_dvd;
  logic [DVS_W-1:0] sel_dvs;
  logic             start_c;
  logic             core_done_c;
  logic [DVD_W-1:0] core_quot_c;
  logic [DVS_W-1:0] core_rem_c;

  // Round-robin search starting at rr_ptr, wrapping at NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
    grant_oh           = '0;
    grant_oh[grant_id] = grant_found;
    sel_dvd            = req_dividend[32'(grant_id)*DVD_W +: DVD_W];
    sel_dvs            = req_divisor[32'(grant_id)*DVS_W +: DVS_W];
  end

  assign req_ready = (state_q == IDLE && !reset) ? grant_oh : '0;

  // Next-state and response register logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
`ifdef DIV_ZERO_CHECK_EN
    rsp_dz_d    = rsp_dz_q;
`endif
    start_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          rr_ptr_d = IDW'((32'(grant_id) + 1) % NREQ);
          rsp_id_d = grant_id;
`ifdef DIV_ZERO_CHECK_EN
          if (sel_dvs == '0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_quot_d  = DIVZERO_QUOT;
            rsp_rem_d   = sel_dvd[DVS_W-1:0];
            rsp_dz_d    = 1'b1;
          end else begin
            start_c = 1'b1;
            state_d = RUN;
          end
`else
          start_c = 1'b1;
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (core_done_c) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_quot_d  = core_quot_c;
          rsp_rem_d   = core_rem_c;
`ifdef DIV_ZERO_CHECK_EN
          rsp_dz_d    = 1'b0;
`endif
        end
      end
      RESP: begin
        // Return to IDLE only; the next grant waits a cycle.
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      busy_q      <= busy_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_dz_q <= 1'b0;
    else       rsp_dz_q <= rsp_dz_d;
  end
  assign rsp_divzero = rsp_dz_q;
`else
  assign rsp_divzero = 1'b0;
`endif

  div_core u_core (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_c),
    .dividend_i  (sel_dvd),
    .divisor_i   (sel_dvs),
    .done_c      (core_done_c),
    .quotient_c  (core_quot_c),
    .remainder_c (core_rem_c)
  );

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign busy          = busy_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one sequential 8-bit by 4-bit unsigned divider among NREQ requesters. It accepts at most one request at a time over a per-requester valid/ready handshake and runs the shared restoring-division core for 8 cycles. It then presents quotient, remainder and requester ID on a single response port with backpressure. It sits between the client blocks and the divider datapath, and is the only block allowed to drive the divider.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), derived; width of requester ID
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending; bit i belongs to requester i
- req_dividend  in  8*NREQ  packed; requester i at [8i+7:8i]
- req_divisor  in  4*NREQ  packed; requester i at [4i+3:4i]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that owns the result
- rsp_quotient  out  8  unsigned quotient
- rsp_remainder  out  4  unsigned remainder
- rsp_divzero  out  1  divisor was zero; only meaningful with the macro, else tied 0
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE:**
  - req_ready is one-hot for the first requester with req_valid high, searching from rr_ptr upward with wrap-around.
  - req_ready is all-zero if no requester is valid.
  - On transfer, latch operands and ID, set rr_ptr = grant+1 mod NREQ, clear iter count, go to RUN.
- **RUN:** one restoring iteration per cycle.
  - Per iteration: partial remainder (5 bits) = {rem[3:0], next dividend bit MSB-first}.
  - If partial remainder ≥ divisor: subtract, shift in quotient bit 1. Else keep it, shift in 0.
  - After the 8th iteration go to RESP.
- **RESP:**
  - rsp_valid is high; all rsp_* hold stable until rsp_valid & rsp_ready.
  - On that handshake go to IDLE. No new grant in the same cycle, so there is one bubble.
- req_ready is all-zero outside IDLE. Requesters must hold valid and operands until granted.
- Operands are unsigned. Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
- The rr_ptr reset value is 0, so requester 0 wins first.

## Timing
- A transfer in cycle c gives RUN in cycles c+1..c+8 and rsp_valid first high in cycle c+9.
- Minimum spacing between grants is 10 cycles when rsp_ready is held high.
- Reset values: state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_quotient 0, rsp_remainder 0, rsp_divzero 0, busy 0.
- req_ready is forced to 0 while reset is asserted.
- Reset mid-RUN or mid-RESP: the operation is aborted and its result discarded. The requester is not re-served unless it re-asserts req_valid.
- A requester dropping req_valid before grant is legal; it is simply skipped.
- A simultaneous request from every requester is served in strict rotation, so no requester waits more than NREQ-1 operations.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - A granted request with divisor 0 skips RUN and enters RESP in cycle c+1.
  - Outputs: quotient 8'hFF, remainder = dividend[3:0], rsp_divzero 1.
- DIV_ZERO_CHECK_EN undefined:
  - Divisor 0 runs the normal 8 iterations.
  - The core must naturally yield quotient 8'hFF and remainder = dividend[3:0] in cycle c+9.
  - rsp_divzero is constant 0.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, RUN, RESP)
  - DVD_W=8, DVS_W=4, ITER=8
  - the divide-by-zero result constant 8'hFF
- Sub-module div_core contains:
  - start pulse
  - operand registers, partial remainder and quotient shift register
  - iteration counter
  - done pulse in its final iteration
- div_arbiter keeps the FSM, the round-robin arbiter, the ID register and the response registers.

## Test plan
- Single request 200/7 on requester 1 → rsp_valid at c+9, rsp_id 1, quotient 28, remainder 4.
- All four requesters valid with rsp_ready high (255/15, 100/3, 9/9, 0/5) → grants in order 0,1,2,3. Results 17 r0, 33 r1, 1 r0, 0 r0.
- rsp_ready held low 5 cycles after rsp_valid → all rsp_* stable and req_ready all-zero; IDLE is reached the cycle after rsp_ready rises.
- Divide by zero 45/0, with macro → rsp_valid at c+1, quotient 0xFF, remainder 0xD, rsp_divzero 1.
- Divide by zero 45/0, without macro → rsp_valid at c+9, same values, rsp_divzero 0.
- Reset asserted in cycle c+4 of a run → outputs return to reset values immediately. After release, requester 0 is granted first when multiple requests are valid.
